framebuffer_dbuf: RTL

Single-clock, multi-page framebuffer for the video path.
- Drawing logic writes pixels into the back page using native (downscaled) coordinates.
- The display scanner reads the front page using full-resolution coordinates, with SCALING_FACTOR pixel replication.
- Page flips are requested at any time and take effect only at a frame boundary.
- A built-in clear engine fills the back page with a constant value.

---
 rtl/framebuffer_dbuf_if.sv | 30 +++
 rtl/framebuffer_dbuf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_dbuf_if.sv
// Pixel write and display read bus for framebuffer_dbuf.
// master = drawing/display side, slave = framebuffer.
interface framebuffer_dbuf_if #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int DW = 8
);
    // Write handshake: a pixel is accepted on a clock edge where wr_valid && wr_ready.
    // The read side has no back-pressure: rd_en is always taken, rd_valid follows two cycles later.
    logic          wr_valid;
    logic          wr_ready;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    modport master (
        output wr_valid, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/framebuffer_dbuf.sv
// Multi-page framebuffer: native-resolution writes to the back page, replicated reads of the
// front page, vsync-aligned flips and a back-page clear engine. `FB_OOB_FLAG_EN adds err_oob.
module framebuffer_dbuf #(
    parameter  int FRAME_WIDTH    = 640,
    parameter  int FRAME_HEIGHT   = 480,
    parameter  int SCALING_FACTOR = 1,
    parameter  int DATA_WIDTH     = 8,
    parameter  int NUM_PAGES      = 2,
    localparam int XW             = $clog2(FRAME_WIDTH),
    localparam int YW             = $clog2(FRAME_HEIGHT),
    localparam int PW             = (NUM_PAGES > 2) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    framebuffer_dbuf_if.slave     bus,
    input  logic                  vsync,
    input  logic                  swap_req,
    output logic                  swap_pending,
    output logic [PW-1:0]         front_page,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_value,
    output logic                  clear_busy,
    output logic                  dbg_clear_state
`ifdef FB_OOB_FLAG_EN
    ,
    output logic                  err_oob
`endif
);
    localparam int SW    = FRAME_WIDTH / SCALING_FACTOR;
    localparam int SH    = FRAME_HEIGHT / SCALING_FACTOR;
    localparam int NPIX  = SW * SH;
    localparam int TOTAL = NUM_PAGES * NPIX;
    localparam int AW    = $clog2(TOTAL);
    localparam int CW    = $clog2(NPIX);
    localparam int SHIFT = $clog2(SCALING_FACTOR);

    if ((FRAME_WIDTH % SCALING_FACTOR) != 0 || (FRAME_HEIGHT % SCALING_FACTOR) != 0 ||
        (1 << SHIFT) != SCALING_FACTOR) begin : g_bad_scale
        $error("framebuffer_dbuf: SCALING_FACTOR must be a power of two dividing both frame dimensions");
    end
    if (NUM_PAGES < 2 || NUM_PAGES > 4) begin : g_bad_pages
        $error("framebuffer_dbuf: NUM_PAGES must be in 2..4");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } clr_state_t;

    logic [DATA_WIDTH-1:0] r_mem [0:TOTAL-1];

    logic [PW-1:0]         r_front_page;
    logic                  r_swap_pending;
    clr_state_t            r_state;
    logic                  r_clr_busy;
    logic [CW-1:0]         r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_clr_val;
    logic                  r_rd_v1;
    logic                  r_rd_oob;
    logic [AW-1:0]         r_rd_addr;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [XW-1:0]         w_wx;
    logic [YW-1:0]         w_wy;
    logic [XW-1:0]         w_rx;
    logic [YW-1:0]         w_ry;
    logic [PW-1:0]         w_back_page;
    logic                  w_wr_ready;
    logic                  w_wr_fire;
    logic                  w_wr_oob;
    logic                  w_rd_oob;
    logic [AW-1:0]         w_wr_addr;
    logic [AW-1:0]         w_clr_addr;
    logic [AW-1:0]         w_rd_addr;
    logic                  w_mem_we;
    logic [AW-1:0]         w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_din;

    assign w_wx = bus.wr_x;
    assign w_wy = bus.wr_y;
    assign w_rx = bus.rd_x;
    assign w_ry = bus.rd_y;

    assign w_back_page = (r_front_page == PW'(NUM_PAGES - 1)) ? '0 : r_front_page + PW'(1);

    // Range checks are done at 32 bits so a dimension equal to 2**XW cannot alias to zero.
    assign w_wr_oob = (32'(w_wx) >= SW) || (32'(w_wy) >= SH);
    assign w_rd_oob = (32'(w_rx) >= FRAME_WIDTH) || (32'(w_ry) >= FRAME_HEIGHT);

    assign w_wr_ready = !r_clr_busy;
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;

    assign w_wr_addr  = AW'(w_back_page) * AW'(NPIX) + AW'(w_wy) * AW'(SW) + AW'(w_wx);
    assign w_clr_addr = AW'(w_back_page) * AW'(NPIX) + AW'(r_clr_cnt);
    assign w_rd_addr  = AW'(r_front_page) * AW'(NPIX) + AW'(w_ry >> SHIFT) * AW'(SW)
                      + AW'(w_rx >> SHIFT);

    // Clearing owns the single write port; user writes are stalled by wr_ready meanwhile.
    assign w_mem_we   = r_clr_busy || (w_wr_fire && !w_wr_oob);
    assign w_mem_addr = r_clr_busy ? w_clr_addr : w_wr_addr;
    assign w_mem_din  = r_clr_busy ? r_clr_val : bus.wr_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // Read pipeline: stage 1 captures the front page with the address, stage 2 the RAM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v1    <= 1'b0;
            r_rd_oob   <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1 <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_oob  <= w_rd_oob;
                r_rd_addr <= w_rd_oob ? '0 : w_rd_addr;
            end
            r_rd_valid <= r_rd_v1;
            if (r_rd_v1) begin
                r_rd_data <= r_rd_oob ? '0 : r_mem[r_rd_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front_page   <= '0;
            r_swap_pending <= 1'b0;
        end else if (vsync && (r_swap_pending || swap_req) && !r_clr_busy) begin
            r_front_page   <= w_back_page;
            r_swap_pending <= 1'b0;
        end else if (swap_req) begin
            r_swap_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_clr_busy <= 1'b0;
            r_clr_cnt  <= '0;
            r_clr_val  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_clr_val  <= clear_value;
                        r_clr_cnt  <= '0;
                        r_clr_busy <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == CW'(NPIX - 1)) begin
                        r_clr_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CW'(1);
                    end
                end
                default: begin
                    r_clr_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FB_OOB_FLAG_EN
    logic r_err_oob;

    // Sticky; a new out-of-range access wins over a clear_start in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_oob <= 1'b0;
        end else if ((w_wr_fire && w_wr_oob) || (bus.rd_en && w_rd_oob)) begin
            r_err_oob <= 1'b1;
        end else if (clear_start) begin
            r_err_oob <= 1'b0;
        end
    end

    assign err_oob = r_err_oob;
`endif

    assign bus.wr_ready    = w_wr_ready;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_data     = r_rd_data;
    assign swap_pending    = r_swap_pending;
    assign front_page      = r_front_page;
    assign clear_busy      = r_clr_busy;
    assign dbg_clear_state = r_state;
endmodule
